// File: rtl/clean_irrigation_scheduler.sv
// clean_irrigation_scheduler: arbitrates the shared pump/valve line between a
// filter-cleaning run (button or periodic) and soil-moisture irrigation, with a
// two-digit BCD seconds countdown for the display.
// Optional feature macro: CLEAN_PERIODIC_EN (automatic cleaning after
// PERIOD_TICKS seconds spent in IDLE/IRRIGATE).
module clean_irrigation_scheduler #(
  parameter int unsigned CLEAN_TIME_S = 7,
  parameter int unsigned IRR_MAX_S    = 60,
  parameter int unsigned PERIOD_TICKS = 3600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_clean,
  input  logic       irrig_req,
  input  logic       water_low,
  input  logic       abort,
  output logic       clean_active,
  output logic       valve_open,
  output logic       clean_pending,
  output logic       done,
  output logic       alarm,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_CLEAN    = 2'b01,
    S_IRRIGATE = 2'b10,
    S_COOLDOWN = 2'b11
  } state_t;

  localparam logic [3:0] CLEAN_TENS  = 4'(CLEAN_TIME_S / 10);
  localparam logic [3:0] CLEAN_UNITS = 4'(CLEAN_TIME_S % 10);
  localparam logic [3:0] IRR_TENS    = 4'(IRR_MAX_S / 10);
  localparam logic [3:0] IRR_UNITS   = 4'(IRR_MAX_S % 10);

  state_t     st;
  logic       count_is_one_c;
  logic [3:0] dec_tens_c;
  logic [3:0] dec_units_c;
  logic       clean_entry_c;
  logic       period_hit_c;

  assign state = st;

  // Countdown status and BCD decrement with borrow, saturating at 00
  always_comb begin
    count_is_one_c = (tens == 4'd0) && (units == 4'd1);
    dec_tens_c     = tens;
    dec_units_c    = units;
    if (units != 4'd0) begin
      dec_units_c = units - 4'd1;
    end else if (tens != 4'd0) begin
      dec_units_c = 4'd9;
      dec_tens_c  = tens - 4'd1;
    end
  end

  // IDLE leaves for CLEAN when a request is latched or arrives this cycle
  assign clean_entry_c = (st == S_IDLE) && (clean_pending || start_clean);

`ifdef CLEAN_PERIODIC_EN
  localparam int unsigned PW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

  logic [PW-1:0] idle_cnt;

  assign period_hit_c = tick && ((st == S_IDLE) || (st == S_IRRIGATE)) &&
                        (idle_cnt == PW'(PERIOD_TICKS - 1));

  // Seconds since the last cleaning; wraps and raises a request at the period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (clean_entry_c) begin
      idle_cnt <= '0;
    end else if (tick && ((st == S_IDLE) || (st == S_IRRIGATE))) begin
      idle_cnt <= period_hit_c ? '0 : idle_cnt + PW'(1);
    end
  end
`else
  assign period_hit_c = 1'b0;
`endif

  // Main sequencer: state, valve enables, pending latch and countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= S_IDLE;
      clean_active  <= 1'b0;
      valve_open    <= 1'b0;
      clean_pending <= 1'b0;
      done          <= 1'b0;
      alarm         <= 1'b0;
      tens          <= 4'd0;
      units         <= 4'd0;
    end else begin
      done  <= 1'b0;
      alarm <= irrig_req && water_low;
      if ((start_clean && (st != S_CLEAN)) || period_hit_c) begin
        clean_pending <= 1'b1;
      end
      case (st)
        S_IDLE: begin
          if (clean_entry_c) begin
            st            <= S_CLEAN;
            clean_active  <= 1'b1;
            clean_pending <= 1'b0;
            tens          <= CLEAN_TENS;
            units         <= CLEAN_UNITS;
          end else if (irrig_req && !water_low) begin
            st         <= S_IRRIGATE;
            valve_open <= 1'b1;
            tens       <= IRR_TENS;
            units      <= IRR_UNITS;
          end
        end
        S_CLEAN: begin
          if (abort) begin
            st           <= S_IDLE;
            clean_active <= 1'b0;
            tens         <= 4'd0;
            units        <= 4'd0;
          end else if (tick) begin
            if (count_is_one_c) begin
              st           <= S_COOLDOWN;
              clean_active <= 1'b0;
              done         <= 1'b1;
              tens         <= 4'd0;
              units        <= 4'd0;
            end else begin
              tens  <= dec_tens_c;
              units <= dec_units_c;
            end
          end
        end
        S_IRRIGATE: begin
          if (abort || !irrig_req || water_low || clean_pending || start_clean ||
              (tick && count_is_one_c)) begin
            st         <= S_COOLDOWN;
            valve_open <= 1'b0;
            tens       <= 4'd0;
            units      <= 4'd0;
          end else if (tick) begin
            tens  <= dec_tens_c;
            units <= dec_units_c;
          end
        end
        S_COOLDOWN: begin
          if (tick) begin
            st <= S_IDLE;
          end
        end
        default: begin
          st           <= S_IDLE;
          clean_active <= 1'b0;
          valve_open   <= 1'b0;
          tens         <= 4'd0;
          units        <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clean_irrigation_scheduler.sv
// Bench for clean_irrigation_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a seconds-level behavioural model.
module tb_clean_irrigation_scheduler;

  localparam int CLEAN_S = 7;
  localparam int IRR_S   = 3;
  localparam int PERIOD  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, start_clean, irrig_req, water_low, abort;
  logic       clean_active, valve_open, clean_pending, done, alarm;
  logic [3:0] tens, units;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 clean, 2 irrigate, 3 cooldown; seconds as plain int
  int m_mode, m_rem, m_idle;
  bit m_pend, m_done, m_alarm;

  clean_irrigation_scheduler #(
    .CLEAN_TIME_S(CLEAN_S),
    .IRR_MAX_S   (IRR_S),
    .PERIOD_TICKS(PERIOD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start_clean  (start_clean),
    .irrig_req    (irrig_req),
    .water_low    (water_low),
    .abort        (abort),
    .clean_active (clean_active),
    .valve_open   (valve_open),
    .clean_pending(clean_pending),
    .done         (done),
    .alarm        (alarm),
    .tens         (tens),
    .units        (units),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_rem = 0; m_idle = 0;
    m_pend = 0; m_done = 0; m_alarm = 0;
  endfunction

  // One clock edge of the scheduler's rules, in whole seconds
  function automatic void model_step(bit tk, bit sc, bit ir, bit wl, bit ab);
    int  nmode = m_mode;
    int  nrem  = m_rem;
    bit  pend  = m_pend;
    m_done  = 0;
    m_alarm = ir && wl;
    if (m_mode == 0) begin
      if (m_pend || sc) begin nmode = 1; nrem = CLEAN_S; end
      else if (ir && !wl) begin nmode = 2; nrem = IRR_S; end
    end else if (m_mode == 1) begin
      if (ab) begin nmode = 0; nrem = 0; end
      else if (tk) begin
        if (m_rem == 1) begin nmode = 3; nrem = 0; m_done = 1; end
        else if (m_rem > 0) nrem = m_rem - 1;
      end
    end else if (m_mode == 2) begin
      if (ab || !ir || wl || m_pend || sc || (tk && m_rem == 1)) begin nmode = 3; nrem = 0; end
      else if (tk && m_rem > 0) nrem = m_rem - 1;
    end else begin
      if (tk) nmode = 0;
    end
    if (sc && m_mode != 1) pend = 1;
`ifdef CLEAN_PERIODIC_EN
    if (tk && (m_mode == 0 || m_mode == 2)) begin
      m_idle++;
      if (m_idle == PERIOD) begin pend = 1; m_idle = 0; end
    end
`endif
    if (nmode == 1 && m_mode != 1) begin pend = 0; m_idle = 0; end
    m_mode = nmode; m_rem = nrem; m_pend = pend;
  endfunction

  task automatic check_all();
    chk("state", 32'(state), 32'(m_mode));
    chk("clean_active", 32'(clean_active), 32'(m_mode == 1));
    chk("valve_open", 32'(valve_open), 32'(m_mode == 2));
    chk("clean_pending", 32'(clean_pending), 32'(m_pend));
    chk("done", 32'(done), 32'(m_done));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("tens", 32'(tens), 32'(m_rem / 10));
    chk("units", 32'(units), 32'(m_rem % 10));
    chk("valve_overlap", 32'(clean_active & valve_open), 32'd0);
  endtask

  task automatic step(input bit tk, input bit sc, input bit ab);
    tick = tk; start_clean = sc; abort = ab;
    @(posedge clk);
    model_step(tk, sc, irrig_req, water_low, ab);
    #1;
    check_all();
    tick = 0; start_clean = 0; abort = 0;
  endtask

  initial begin
    int dones;
    reset = 1; tick = 0; start_clean = 0; irrig_req = 0; water_low = 0; abort = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset = 0;

    // Button-started cleaning runs to completion, then cooldown, then idle
    step(0, 1, 0);
    dones = 0;
    for (int i = 0; i < CLEAN_S; i++) begin
      step(1, 0, 0);
      if (done) dones++;
    end
    chk("done_count", 32'(dones), 32'd1);
    step(0, 0, 0);
    step(1, 0, 0);

    // Irrigation forced release after IRR_S ticks, then re-grant
    irrig_req = 1;
    step(0, 0, 0);
    for (int i = 0; i < IRR_S; i++) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("regrant", 32'(valve_open), 32'd1);

    // Cleaning preempts irrigation
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    irrig_req = 0;
    while (m_mode != 0) step(1, 0, 0);

    // Low water blocks and alarms, then mid-run low water releases
    irrig_req = 1; water_low = 1;
    step(0, 0, 0);
    step(1, 0, 0);
    water_low = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    water_low = 1;
    step(0, 0, 0);
    step(1, 0, 0);
    irrig_req = 0; water_low = 0;
    step(0, 0, 0);

    // Abort together with the final cleaning tick: no done, back to idle
    step(0, 1, 0);
    for (int i = 0; i < 20 && m_rem > 1; i++) step(1, 0, 0);
    step(1, 0, 1);
    chk("abort_final_done", 32'(done), 32'd0);

    // Asynchronous reset mid-clean drops the cleaning valve between edges
    step(0, 1, 0);
    step(1, 0, 0);
    #2;
    reset = 1;
    #1;
    chk("async_rst_clean", 32'(clean_active), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    check_all();

    // Idle ticks: periodic cleaning request when the feature is built in
    for (int i = 0; i < PERIOD + 2; i++) step(1, 0, 0);
    step(0, 0, 0);
    while (m_mode != 0) step(1, 0, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(14) == 0) irrig_req = ~irrig_req;
      if ($urandom_range(24) == 0) water_low = ~water_low;
      step(bit'($urandom_range(1)), bit'($urandom_range(19) == 0),
           bit'($urandom_range(39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clean_irrigation_scheduler.md
Name: clean_irrigation_scheduler

Overview:
Shares the single pump/valve line between two requesters: the irrigation request from the soil-moisture logic and the filter-cleaning request from the panel button. It sequences a fixed-length cleaning run with a seconds countdown, shown as two BCD digits for the 7-segment decoders, and grants irrigation only when cleaning is idle and water is available. It sits between the sensor/button conditioning logic and the valve drivers and display decoders.

Parameters:
CLEAN_TIME_S, 7, cleaning run length in seconds (1..99)
IRR_MAX_S, 60, maximum continuous irrigation in seconds before a forced release (1..99)
PERIOD_TICKS, 3600, idle seconds between automatic cleanings (only with CLEAN_PERIODIC_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle 1 Hz enable pulse from the prescaler
start_clean  input  1  cleaning request pulse from the debounced button
irrig_req  input  1  level request from the moisture comparator (1 = soil dry)
water_low  input  1  reservoir-low level (1 = insufficient water)
abort  input  1  synchronous stop pulse; cancels the active run
clean_active  output  1  cleaning valve/pump enable
valve_open  output  1  irrigation valve enable
clean_pending  output  1  cleaning request latched and waiting
done  output  1  one-cycle pulse when a cleaning run completes normally
alarm  output  1  set while irrigation is blocked by water_low
tens  output  4  BCD tens of the remaining seconds
units  output  4  BCD units of the remaining seconds
state  output  2  00 IDLE, 01 CLEAN, 10 IRRIGATE, 11 COOLDOWN

Behaviour:
- Reset (async): state IDLE. All 1-bit outputs 0. tens/units = 0. Pending latch cleared. Counters cleared.
- The remaining-time counter is held as two BCD digits and decrements only on tick. Borrow rule: when units is 0, units becomes 9 and tens decrements. The counter never goes below 00.
- pending: set by start_clean in any state except CLEAN. Cleared on entry to CLEAN.
- IDLE: priority order is pending, then irrig_req.
  - If pending, go to CLEAN and load the counter with CLEAN_TIME_S.
  - Else if irrig_req && !water_low, go to IRRIGATE and load the counter with IRR_MAX_S.
  - A transition takes effect on the next clk edge. Outputs are registered and assert in the same cycle state changes.
- CLEAN: clean_active = 1, valve_open = 0.
  - A tick while the counter is 01 sets the counter to 00, pulses done for 1 cycle and goes to COOLDOWN.
  - abort goes to IDLE immediately, with counter = 00 and no done.
  - start_clean during CLEAN is ignored.
- IRRIGATE: valve_open = 1.
  - Go to COOLDOWN on any of: irrig_req falls, water_low rises, pending is set, a tick at count 01 (forced release), or abort.
  - Cleaning therefore preempts irrigation within 1 cycle.
- COOLDOWN: both valves closed for exactly one tick period (the counter is unused and reads 00). On the next tick, return to IDLE. Purpose: no back-to-back valve switching.
- alarm = irrig_req && water_low, registered, in every state.
- tens/units show the live counter in CLEAN and IRRIGATE, and 00 elsewhere.
- Simultaneous events in one cycle:
  - abort beats tick.
  - start_clean and irrig_req together in IDLE: CLEAN wins.
  - tick at 01 and abort together in CLEAN: abort wins, no done.
- reset asserted mid-run de-energizes both valves asynchronously.

Optional Feature:
CLEAN_PERIODIC_EN
- Defined: a seconds counter runs on tick while the state is IDLE or IRRIGATE. It clears on entry to CLEAN. On reaching PERIOD_TICKS it sets pending and clears. The resulting cleaning is indistinguishable from a button request.
- Undefined: no idle counter. pending is set only by start_clean.

Test Plan:
1. Reset released, start_clean pulse → state 01 next cycle; tens/units 0/7; after 7 ticks done pulses once, state 11, both valves 0; next tick state 00.
2. irrig_req=1, water_low=0 in IDLE → valve_open=1, count 6/0. With IRR_MAX_S=3: after 3 ticks forced release to COOLDOWN, then IDLE, then re-grant while irrig_req is still 1.
3. During IRRIGATE, pulse start_clean → clean_pending=1 and next cycle COOLDOWN. After one tick IDLE, then CLEAN; clean_pending clears on CLEAN entry; valve_open never overlaps clean_active.
4. irrig_req=1 with water_low=1 → alarm=1, valve_open stays 0. Drop water_low → IRRIGATE grant; raise water_low mid-run → COOLDOWN.
5. abort in the same cycle as the final tick of CLEAN → state 00, no done pulse, count 00. Reset mid-CLEAN → clean_active drops without waiting for clk.
6. With CLEAN_PERIODIC_EN and PERIOD_TICKS=5: 5 idle ticks → pending set, CLEAN entered. Without the macro the same stimulus stays IDLE.
